// File: rtl/runway_decoder.sv
// Runway light sequence decoder: classifies successive lamp patterns into
// wind modes and locks once a class repeats LOCK_COUNT times in a row.
module runway_decoder #(
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample,
    input  logic [2:0] led,
    output logic [1:0] mode,
    output logic       locked,
    output logic       error
);

    localparam int unsigned LW = 3;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LOCK_CNT = CW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'b00,
        S_SEARCH = 2'b01,
        S_TRACK  = 2'b10,
        S_LOCK   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CL_CALM    = 2'b00,
        CL_LEFT    = 2'b01,
        CL_RIGHT   = 2'b10,
        CL_INVALID = 2'b11
    } class_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   prev_q, prev_d;
    logic [CW-1:0]   count_q, count_d;
    class_e          class_q, class_d;
    logic [1:0]      mode_q, mode_d;
    logic            locked_q, locked_d;
    logic            error_q, error_d;

    class_e          cls;
    logic [CW-1:0]   cnt_inc;

    // Classify the (prev, led) transition pair
    always_comb begin
        cls = CL_INVALID;
        case ({prev_q, led})
            {3'b101, 3'b010}, {3'b010, 3'b101}:                   cls = CL_CALM;
            {3'b001, 3'b010}, {3'b010, 3'b100}, {3'b100, 3'b001}: cls = CL_LEFT;
            {3'b100, 3'b010}, {3'b010, 3'b001}, {3'b001, 3'b100}: cls = CL_RIGHT;
            default:                                              cls = CL_INVALID;
        endcase
    end

    assign cnt_inc = count_q + CW'(1);

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        count_d  = count_q;
        class_d  = class_q;
        mode_d   = mode_q;
        locked_d = locked_q;
        error_d  = 1'b0;

        if (sample) begin
            prev_d = led;
            unique case (state_q)
                S_EMPTY: begin
                    state_d = S_SEARCH;
                end
                S_SEARCH: begin
                    if (cls != CL_INVALID) begin
                        class_d = cls;
                        count_d = CW'(1);
                        if (LOCK_CNT <= CW'(1)) begin
                            state_d  = S_LOCK;
                            mode_d   = cls;
                            locked_d = 1'b1;
                        end else begin
                            state_d = S_TRACK;
                        end
                    end
                end
                S_TRACK: begin
                    if (cls == CL_INVALID) begin
                        state_d = S_SEARCH;
                        count_d = '0;
                    end else if (cls == class_q) begin
                        count_d = cnt_inc;
                        if (cnt_inc >= LOCK_CNT) begin
                            state_d  = S_LOCK;
                            mode_d   = class_q;
                            locked_d = 1'b1;
                        end
                    end else begin
                        class_d = cls;
                        count_d = CW'(1);
                        if (LOCK_CNT <= CW'(1)) begin
                            state_d  = S_LOCK;
                            mode_d   = cls;
                            locked_d = 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    if (cls == CL_INVALID) begin
                        state_d  = S_SEARCH;
                        count_d  = '0;
                        locked_d = 1'b0;
                        error_d  = 1'b1;
                    end else if (cls == class_q) begin
                        count_d = LOCK_CNT;
                    end else begin
                        class_d  = cls;
                        count_d  = CW'(1);
                        error_d  = 1'b1;
                        if (LOCK_CNT <= CW'(1)) begin
                            mode_d   = cls;
                            locked_d = 1'b1;
                        end else begin
                            state_d  = S_TRACK;
                            locked_d = 1'b0;
                        end
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_EMPTY;
            prev_q   <= '0;
            count_q  <= '0;
            class_q  <= CL_CALM;
            mode_q   <= 2'b00;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            count_q  <= count_d;
            class_q  <= class_d;
            mode_q   <= mode_d;
            locked_q <= locked_d;
            error_q  <= error_d;
        end
    end

    assign mode   = mode_q;
    assign locked = locked_q;
    assign error  = error_q;

endmodule

// File: tb/tb_runway_decoder.sv
// Directed bench for runway_decoder with LOCK_COUNT=3 and LOCK_COUNT=1 instances.
module tb_runway_decoder;

    logic       clk;
    logic       reset;
    logic       sample;
    logic [2:0] led;
    logic [1:0] mode_a, mode_b;
    logic       locked_a, locked_b;
    logic       error_a, error_b;

    int checks = 0;
    int errors = 0;

    runway_decoder #(.LOCK_COUNT(3)) dut_a (
        .clk(clk), .reset(reset), .sample(sample), .led(led),
        .mode(mode_a), .locked(locked_a), .error(error_a)
    );

    runway_decoder #(.LOCK_COUNT(1)) dut_b (
        .clk(clk), .reset(reset), .sample(sample), .led(led),
        .mode(mode_b), .locked(locked_b), .error(error_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check mode/locked/error of the LOCK_COUNT=3 instance
    task automatic chk_a(input string tag, input logic [1:0] m, input logic l, input logic e);
        chk({tag, ".mode"},   4'(mode_a),   4'(m));
        chk({tag, ".locked"}, 4'(locked_a), 4'(l));
        chk({tag, ".error"},  4'(error_a),  4'(e));
    endtask

    task automatic chk_b(input string tag, input logic [1:0] m, input logic l, input logic e);
        chk({tag, ".mode"},   4'(mode_b),   4'(m));
        chk({tag, ".locked"}, 4'(locked_b), 4'(l));
        chk({tag, ".error"},  4'(error_b),  4'(e));
    endtask

    // Strobe one pattern; sample stays high so consecutive calls are back-to-back
    task automatic samp(input logic [2:0] v);
        sample = 1'b1;
        led    = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sample = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        sample = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        sample = 1'b0;
        led    = 3'b000;
        #3;
        chk_a("reset_a", 2'b00, 1'b0, 1'b0);
        chk_b("reset_b", 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // CALM lock after three transitions, then saturated hold
        samp(3'b101); chk_a("calm_s1", 2'b00, 1'b0, 1'b0);
        samp(3'b010); chk_a("calm_s2", 2'b00, 1'b0, 1'b0);
        samp(3'b101); chk_a("calm_s3", 2'b00, 1'b0, 1'b0);
        samp(3'b010); chk_a("calm_s4", 2'b00, 1'b1, 1'b0);
        samp(3'b101); chk_a("calm_hold1", 2'b00, 1'b1, 1'b0);
        samp(3'b010); chk_a("calm_hold2", 2'b00, 1'b1, 1'b0);
        idle(3);      chk_a("calm_idle", 2'b00, 1'b1, 1'b0);

        // LEFT lock, break to RIGHT, relock RIGHT
        do_reset();
        samp(3'b001); chk_a("left_s1", 2'b00, 1'b0, 1'b0);
        samp(3'b010); chk_a("left_s2", 2'b00, 1'b0, 1'b0);
        samp(3'b100); chk_a("left_s3", 2'b00, 1'b0, 1'b0);
        samp(3'b001); chk_a("left_lock", 2'b01, 1'b1, 1'b0);
        samp(3'b100); chk_a("left_break", 2'b01, 1'b0, 1'b1);
        idle(1);      chk_a("left_break_gap", 2'b01, 1'b0, 1'b0);
        samp(3'b010); chk_a("right_t2", 2'b01, 1'b0, 1'b0);
        samp(3'b001); chk_a("right_lock", 2'b10, 1'b1, 1'b0);

        // LEFT lock broken by an invalid pattern, then rebuild from SEARCH
        do_reset();
        samp(3'b001); samp(3'b010); samp(3'b100); samp(3'b001);
        chk_a("inv_locked", 2'b01, 1'b1, 1'b0);
        samp(3'b111); chk_a("inv_break", 2'b01, 1'b0, 1'b1);
        idle(1);      chk_a("inv_gap", 2'b01, 1'b0, 1'b0);
        samp(3'b010); chk_a("inv_after", 2'b01, 1'b0, 1'b0);
        samp(3'b100); chk_a("inv_t1", 2'b01, 1'b0, 1'b0);
        samp(3'b001); chk_a("inv_t2", 2'b01, 1'b0, 1'b0);
        samp(3'b010); chk_a("inv_relock", 2'b01, 1'b1, 1'b0);

        // Repeated identical patterns never lock
        do_reset();
        for (int i = 0; i < 4; i++) begin
            samp(3'b010);
            chk_a("repeat", 2'b00, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-stream while locked CALM
        do_reset();
        samp(3'b101); samp(3'b010); samp(3'b101); samp(3'b010);
        chk_a("ar_locked", 2'b00, 1'b1, 1'b0);
        sample = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_a("ar_async", 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_a("ar_release", 2'b00, 1'b0, 1'b0);
        samp(3'b101); chk_a("ar_first", 2'b00, 1'b0, 1'b0);
        samp(3'b010); chk_a("ar_second", 2'b00, 1'b0, 1'b0);

        // LOCK_COUNT=1: immediate lock, idle hold, immediate relock on class change
        do_reset();
        samp(3'b100); chk_b("lc1_s1", 2'b00, 1'b0, 1'b0);
        samp(3'b010); chk_b("lc1_lock", 2'b10, 1'b1, 1'b0);
        idle(20);     chk_b("lc1_idle", 2'b10, 1'b1, 1'b0);
        samp(3'b001); chk_b("lc1_same", 2'b10, 1'b1, 1'b0);
        samp(3'b010); chk_b("lc1_relock", 2'b01, 1'b1, 1'b1);
        idle(1);      chk_b("lc1_after", 2'b01, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/runway_decoder.md
RUNWAY_DECODER -- requirements
Module: runway_decoder

Interface
REQ-001 Parameter: LOCK_COUNT, default 3, number of consecutive same-class transitions required to lock (legal range 1..7).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0); clears all state immediately.
REQ-004 sample  input  1  one-cycle strobe; led is valid and is captured on this cycle.
REQ-005 led  input  3  runway light pattern under observation (bit 2 = leftmost lamp).
REQ-006 mode  output  2  decoded wind mode: 00 calm, 01 right-to-left, 10 left-to-right; 11 never driven.
REQ-007 locked  output  1  high while mode is backed by at least LOCK_COUNT consecutive matching transitions.
REQ-008 error  output  1  one-cycle pulse when a locked stream breaks.

Function
REQ-009 Transition classification uses the previous captured pattern (prev) and the current led on a sample cycle.
REQ-010 CALM class: 101->010 and 010->101.
REQ-011 LEFT class (mode 01): 001->010, 010->100 and 100->001.
REQ-012 RIGHT class (mode 10): 100->010, 010->001 and 001->100.
REQ-013 Any other pair is INVALID, including repeated identical patterns and any pattern 000, 011, 110 or 111.
REQ-014 prev is updated to led on every sample cycle, whether the transition is valid or not; it is not updated when sample is low.
REQ-015 FSM states: EMPTY (no prev), SEARCH, TRACK, LOCK.
REQ-016 EMPTY: on sample, capture prev, go to SEARCH; outputs unchanged.
REQ-017 SEARCH: on a valid-class sample, record the class, set count=1, go to TRACK; with LOCK_COUNT=1, go directly to LOCK; on INVALID, stay in SEARCH.
REQ-018 TRACK: a same-class sample increments count; when count reaches LOCK_COUNT, go to LOCK.
REQ-019 TRACK: a different valid class restarts with count=1 and the new class; INVALID returns to SEARCH with count=0.
REQ-020 LOCK entry: on the entering cycle, set mode to the tracked class and locked to 1.
REQ-021 LOCK: a same-class sample holds state, and count saturates at LOCK_COUNT.
REQ-022 LOCK: a different valid class clears locked, pulses error, loads the new class with count=1 and goes to TRACK (or re-locks immediately when LOCK_COUNT=1).
REQ-023 LOCK: INVALID clears locked, pulses error and goes to SEARCH.
REQ-024 mode holds its last locked value while unlocked; it changes only on LOCK entry.
REQ-025 Latency: mode, locked and error update on the clock edge that samples the sample strobe, and are visible the following cycle.
REQ-026 error is high for exactly one cycle per break; it never asserts outside LOCK exit.
REQ-027 count is 3 bits wide and never wraps.
REQ-028 All outputs are registered, with no combinational path from inputs to outputs.
REQ-029 Back-to-back sample strobes on consecutive cycles are each processed fully.

Reset
REQ-030 While reset=0: state=EMPTY, prev=000, count=0, class=CALM, mode=00, locked=0, error=0.
REQ-031 Reset asserted mid-stream takes effect immediately, with no error pulse.
REQ-032 After release, the first sample only captures prev and causes no classification.

Verification
REQ-033 Reset, then samples 101,010,101,010 (LOCK_COUNT=3) -> locked rises one cycle after the 4th sample; mode=00; error stays 0.
REQ-034 Samples 001,010,100,001 -> mode=01, locked=1; then 001->100 -> locked=0, error pulses one cycle, mode stays 01; after 100->010 and 010->001 (three RIGHT transitions total) -> mode=10, locked=1.
REQ-035 While locked LEFT, sample 111 -> locked=0, error=1 for one cycle, state SEARCH; next sample 010 gives INVALID (111->010), still unlocked.
REQ-036 Samples with repeated 010,010,010 -> never locks; mode unchanged from reset (00).
REQ-037 Locked CALM, then reset=0 for one cycle mid-stream -> mode=00, locked=0, error=0 asynchronously; next sample produces no output change.
REQ-038 LOCK_COUNT=1: samples 100,010 -> locked=1, mode=10 after a single transition; sample gaps of many cycles with sample low leave all outputs unchanged.
